// File: rtl/ext_bus_responder.sv
// External-bus peripheral: GPIO register, 32-bit compare timer with interrupt,
// and a push-only FIFO drained by a valid/ready consumer.

module ext_bus_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [W-1:0]       push_data,
  input  logic               ready,
  output logic [W-1:0]       head,
  output logic               valid,
  output logic               full,
  output logic               empty,
  output logic [$clog2(DEPTH):0] count,
  output logic               drop
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          pop, accept;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign valid  = !empty;
  assign pop    = valid && ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;
  assign head   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module ext_bus_responder #(
  parameter int FIFO_DEPTH = 8,
  parameter int GPIO_W     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       ADDR,
  input  logic              CS,
  input  logic              WR_RD,
  input  logic [31:0]       Data_BUS_WRITE,
  output logic [31:0]       Data_BUS_READ,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq,
  output logic [31:0]       fifo_out_data,
  output logic              fifo_out_valid,
  input  logic              fifo_out_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {
    REG_GPIO   = 3'd0,
    REG_COUNT  = 3'd1,
    REG_CMP    = 3'd2,
    REG_STATUS = 3'd3,
    REG_FIFO   = 3'd4,
    REG_CTRL   = 3'd5
  } reg_sel_e;

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two, at least 2");
    end
    if (GPIO_W < 1 || GPIO_W > 32) begin : g_bad_gpio
      $error("GPIO_W must be 1..32");
    end
  endgenerate

  logic [2:0]        sel;
  logic              wr_en, rd_en;
  logic              wr_gpio, wr_count, wr_cmp, wr_status, wr_fifo, wr_ctrl;
  logic              unused_addr;

  logic [GPIO_W-1:0] gpio_q;
  logic [31:0]       count_q, cmp_q;
  logic [1:0]        ctrl_q;
  logic              irq_pending, overflow;
  logic              timer_en, irq_en, hit;

  logic              fifo_full, fifo_empty, fifo_drop;
  logic [CW-1:0]     fifo_cnt;
  logic [4:0]        fifo_cnt5;
  logic [31:0]       gpio_ext, status, rd_mux;

  assign sel         = ADDR[2:0];
  assign unused_addr = ^ADDR[31:3];
  assign wr_en       = CS && WR_RD;
  assign rd_en       = CS && !WR_RD;
  assign wr_gpio     = wr_en && (sel == REG_GPIO);
  assign wr_count    = wr_en && (sel == REG_COUNT);
  assign wr_cmp      = wr_en && (sel == REG_CMP);
  assign wr_status   = wr_en && (sel == REG_STATUS);
  assign wr_fifo     = wr_en && (sel == REG_FIFO);
  assign wr_ctrl     = wr_en && (sel == REG_CTRL);

  assign timer_en = ctrl_q[0];
  assign irq_en   = ctrl_q[1];
  assign hit      = timer_en && (count_q == cmp_q);
  assign irq      = irq_pending && irq_en;
  assign gpio_out = gpio_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) gpio_q <= '0;
    else if (wr_gpio) gpio_q <= Data_BUS_WRITE[GPIO_W-1:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q     <= '0;
      cmp_q       <= '1;
      ctrl_q      <= '0;
      irq_pending <= 1'b0;
    end else begin
      if (wr_cmp)  cmp_q  <= Data_BUS_WRITE;
      if (wr_ctrl) ctrl_q <= Data_BUS_WRITE[1:0];
      if (wr_count)      count_q <= Data_BUS_WRITE;
      else if (timer_en) count_q <= count_q + 32'd1;
      // A compare hit in the same cycle as a W1C keeps the interrupt pending.
      if (hit)                                 irq_pending <= 1'b1;
      else if (wr_status && Data_BUS_WRITE[0]) irq_pending <= 1'b0;
    end
  end

  ext_bus_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (wr_fifo),
    .push_data (Data_BUS_WRITE),
    .ready     (fifo_out_ready),
    .head      (fifo_out_data),
    .valid     (fifo_out_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt),
    .drop      (fifo_drop)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
    else if (wr_status && Data_BUS_WRITE[3]) overflow <= 1'b0;
  end

  assign fifo_cnt5 = 5'(fifo_cnt);

  always_comb begin
    gpio_ext = '0;
    gpio_ext[GPIO_W-1:0] = gpio_q;
    status = '0;
    status[0]   = irq_pending;
    status[1]   = fifo_empty;
    status[2]   = fifo_full;
    status[3]   = overflow;
    status[8:4] = fifo_cnt5;
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_GPIO:   rd_mux = gpio_ext;
      REG_COUNT:  rd_mux = count_q;
      REG_CMP:    rd_mux = cmp_q;
      REG_STATUS: rd_mux = status;
      REG_CTRL:   rd_mux = {30'd0, ctrl_q};
      default:    rd_mux = '0;
    endcase
  end

  // Read data is held between reads so the write-back stage sees a stable value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) Data_BUS_READ <= '0;
    else if (rd_en) Data_BUS_READ <= rd_mux;
  end
endmodule
